// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start, 8 data bits LSB first,
// optional parity, 1 or 2 stop bits. Line idles high.
module uart_tx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_serial
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic SB_LAST = (STOP_BITS == 2);
  localparam logic PEN = (PARITY_EN != 0);
  localparam logic ODD = (PARITY_ODD != 0);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (CPB < 2) begin : g_bad_cpb
    $error("uart_tx: CLK_HZ/BAUD must be >= 2");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0]      shreg, shreg_n;
  logic            par, par_n;
  logic            sb, sb_n;
  logic            serial_n;
  logic            ready_n;
  logic            done_n;
  logic            tick;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      sb        <= 1'b0;
      tx_serial <= 1'b1;
      tx_ready  <= 1'b1;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      par       <= par_n;
      sb        <= sb_n;
      tx_serial <= serial_n;
      tx_ready  <= ready_n;
      tx_done   <= done_n;
    end
  end

  // Outputs are computed for the state being entered,
  // so the registered line leads with no extra latency.
  always_comb begin
    state_n  = state;
    cnt_n    = tick ? '0 : cnt + 1'b1;
    idx_n    = idx;
    shreg_n  = shreg;
    par_n    = par;
    sb_n     = sb;
    serial_n = tx_serial;
    ready_n  = 1'b0;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n    = '0;
        idx_n    = '0;
        sb_n     = 1'b0;
        serial_n = 1'b1;
        ready_n  = 1'b1;
        if (tx_start) begin
          shreg_n  = tx_data;
          par_n    = (^tx_data) ^ ODD;
          state_n  = START;
          serial_n = 1'b0;
          ready_n  = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_n  = DATA;
          idx_n    = '0;
          serial_n = shreg[0];
        end
      end
      DATA: begin
        if (tick) begin
          shreg_n = shreg >> 1;
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) begin
            sb_n = 1'b0;
            if (PEN) begin
              state_n  = PARITY;
              serial_n = par;
            end else begin
              state_n  = STOP;
              serial_n = 1'b1;
            end
          end else begin
            serial_n = shreg[1];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_n  = STOP;
          sb_n     = 1'b0;
          serial_n = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (sb == SB_LAST) begin
            state_n  = IDLE;
            ready_n  = 1'b1;
            done_n   = 1'b1;
            serial_n = 1'b1;
          end else begin
            sb_n = 1'b1;
          end
        end
      end
      default: begin
        state_n  = IDLE;
        cnt_n    = '0;
        serial_n = 1'b1;
        ready_n  = 1'b1;
      end
    endcase
  end

endmodule
